// File: rtl/reg_file_wb.sv
// RV32I architectural register file: one writeback port, two combinational
// read ports with optional same-cycle forwarding, and a pending-write scoreboard.
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [ADDR_W-1:0]     i_RdAddrA,
  input  logic [ADDR_W-1:0]     i_RdAddrB,
  output logic [DATA_W-1:0]     o_RdDataA,
  output logic [DATA_W-1:0]     o_RdDataB,
  input  logic                  i_WrEn,
  input  logic [ADDR_W-1:0]     i_WrAddr,
  input  logic [DATA_W-1:0]     i_WrData,
  input  logic                  i_IssueEn,
  input  logic [ADDR_W-1:0]     i_IssueAddr,
  output logic                  o_BusyA,
  output logic                  o_BusyB,
  output logic [2**ADDR_W-1:0]  o_BusyVec
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              wr_hit_s;
  logic              iss_hit_s;

  logic [ADDR_W-1:0] rd_addr_s [2];
  logic [DATA_W-1:0] rd_data_s [2];
  logic              rd_busy_s [2];

  assign wr_hit_s  = i_WrEn    && (i_WrAddr    != {ADDR_W{1'b0}});
  assign iss_hit_s = i_IssueEn && (i_IssueAddr != {ADDR_W{1'b0}});

  // Register next state: commit the writeback, x0 is never written.
  always_comb begin
    regs_d = regs_q;
    if (wr_hit_s) begin
      regs_d[i_WrAddr] = i_WrData;
    end else begin
      regs_d = regs_q;
    end
  end

  // Scoreboard next state: a new issue outranks the retiring writeback.
  always_comb begin
    busy_d = busy_q;
    for (int n = 0; n < NREG; n++) begin
      if (n == 0) begin
        busy_d[n] = 1'b0;
      end else if (iss_hit_s && (i_IssueAddr == ADDR_W'(n))) begin
        busy_d[n] = 1'b1;
      end else if (wr_hit_s && (i_WrAddr == ADDR_W'(n))) begin
        busy_d[n] = 1'b0;
      end else begin
        busy_d[n] = busy_q[n];
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int n = 0; n < NREG; n++) begin
        regs_q[n] <= {DATA_W{1'b0}};
      end
      busy_q <= {NREG{1'b0}};
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign rd_addr_s[0] = i_RdAddrA;
  assign rd_addr_s[1] = i_RdAddrB;

  // Read ports; reset gating keeps a forwarded write from leaking out while held in reset.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_s[p] = {DATA_W{1'b0}};
      rd_busy_s[p] = 1'b0;
      if (i_Rst || (rd_addr_s[p] == {ADDR_W{1'b0}})) begin
        rd_data_s[p] = {DATA_W{1'b0}};
        rd_busy_s[p] = 1'b0;
      end else if (BYPASS && wr_hit_s && (i_WrAddr == rd_addr_s[p])) begin
        rd_data_s[p] = i_WrData;
        if (iss_hit_s && (i_IssueAddr == rd_addr_s[p])) begin
          rd_busy_s[p] = busy_q[rd_addr_s[p]];
        end else begin
          rd_busy_s[p] = 1'b0;
        end
      end else begin
        rd_data_s[p] = regs_q[rd_addr_s[p]];
        rd_busy_s[p] = busy_q[rd_addr_s[p]];
      end
    end
  end

  assign o_RdDataA = rd_data_s[0];
  assign o_RdDataB = rd_data_s[1];
  assign o_BusyA   = rd_busy_s[0];
  assign o_BusyB   = rd_busy_s[1];
  assign o_BusyVec = busy_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Randomised self-checking bench for reg_file_wb: a forwarding and a
// non-forwarding instance share stimulus and are compared to an array model.
module tb_reg_file_wb;

  logic        clk;
  logic        rst;
  logic [4:0]  ra, rb, wa, ia;
  logic        we, ie;
  logic [31:0] wd;

  logic [31:0] rda_b, rdb_b, rda_n, rdb_n;
  logic        bsa_b, bsb_b, bsa_n, bsb_n;
  logic [31:0] bv_b, bv_n;

  logic [31:0] mem_m  [32];
  bit          busy_m [32];

  int n_tests = 0;
  int n_fail  = 0;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_RdAddrA(ra), .i_RdAddrB(rb),
    .o_RdDataA(rda_b), .o_RdDataB(rdb_b), .i_WrEn(we), .i_WrAddr(wa),
    .i_WrData(wd), .i_IssueEn(ie), .i_IssueAddr(ia),
    .o_BusyA(bsa_b), .o_BusyB(bsb_b), .o_BusyVec(bv_b)
  );

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .i_Clk(clk), .i_Rst(rst), .i_RdAddrA(ra), .i_RdAddrB(rb),
    .o_RdDataA(rda_n), .o_RdDataB(rdb_n), .i_WrEn(we), .i_WrAddr(wa),
    .i_WrData(wd), .i_IssueEn(ie), .i_IssueAddr(ia),
    .o_BusyA(bsa_n), .o_BusyB(bsb_n), .o_BusyVec(bv_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (rst || a == 5'd0) return 32'd0;
    if (byp && we && wa == a) return wd;
    return mem_m[a];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] a, input bit byp);
    if (rst || a == 5'd0) return 32'd0;
    if (byp && we && wa == a && !(ie && ia == a)) return 32'd0;
    return {31'd0, busy_m[a]};
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [31:0] v;
    v = 32'd0;
    for (int n = 1; n < 32; n++) v[n] = busy_m[n];
    return v;
  endfunction

  task automatic model_clear();
    for (int n = 0; n < 32; n++) begin
      mem_m[n]  = 32'd0;
      busy_m[n] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      if (we && wa != 5'd0) begin
        mem_m[wa]  = wd;
        busy_m[wa] = 1'b0;
      end
      if (ie && ia != 5'd0) busy_m[ia] = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("byp_rda",  rda_b, exp_rd(ra, 1'b1));
    chk("byp_rdb",  rdb_b, exp_rd(rb, 1'b1));
    chk("byp_bsa",  {31'd0, bsa_b}, exp_busy(ra, 1'b1));
    chk("byp_bsb",  {31'd0, bsb_b}, exp_busy(rb, 1'b1));
    chk("byp_vec",  bv_b, exp_vec());
    chk("nb_rda",   rda_n, exp_rd(ra, 1'b0));
    chk("nb_rdb",   rdb_n, exp_rd(rb, 1'b0));
    chk("nb_bsa",   {31'd0, bsa_n}, exp_busy(ra, 1'b0));
    chk("nb_bsb",   {31'd0, bsb_n}, exp_busy(rb, 1'b0));
    chk("nb_vec",   bv_n, exp_vec());
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic do_cycle();
    #2;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; ie = 1'b0; wa = 5'd0; ia = 5'd0; wd = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    model_clear();
    ra = 5'd5; rb = 5'd7;
    we = 1'b1; wa = 5'd5; wd = 32'hCAFE_F00D; ie = 1'b1; ia = 5'd7;
    #2;
    check_all();
    chk("rst_rda", rda_b, 32'd0);
    chk("rst_vec", bv_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    do_cycle();

    // Reset asserted asynchronously in the middle of a cycle
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ie = 1'b1; ia = 5'd7;
    do_cycle();
    idle();
    ra = 5'd5; rb = 5'd7;
    #1;
    chk("pre_rst_x5", rda_n, 32'hDEAD_BEEF);
    chk("pre_rst_b7", {31'd0, bsb_n}, 32'd1);
    rst = 1'b1;
    model_clear();
    #1;
    chk("mid_rst_x5", rda_b, 32'd0);
    chk("mid_rst_vec", bv_b, 32'd0);
    @(negedge clk);
    do_cycle();
    rst = 1'b0;
    do_cycle();
    chk("post_rst_x5", rda_n, 32'd0);

    // x0 hardwire
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ie = 1'b1; ia = 5'd0;
    ra = 5'd0; rb = 5'd0;
    #1;
    chk("x0_rda", rda_b, 32'd0);
    chk("x0_rdb", rdb_b, 32'd0);
    do_cycle();
    idle();
    chk("x0_vec0", {31'd0, bv_b[0]}, 32'd0);
    do_cycle();

    // Write then read without forwarding
    rb = 5'd31; we = 1'b1; wa = 5'd31; wd = 32'h1234_5678;
    #1;
    chk("wr_before", rdb_n, 32'd0);
    do_cycle();
    idle();
    #1;
    chk("wr_after", rdb_n, 32'h1234_5678);
    do_cycle();

    // Same-cycle forwarding to both ports
    ra = 5'd10; rb = 5'd10; we = 1'b1; wa = 5'd10; wd = 32'hA5A5_A5A5;
    #1;
    chk("byp_a", rda_b, 32'hA5A5_A5A5);
    chk("byp_b", rdb_b, 32'hA5A5_A5A5);
    do_cycle();
    idle();
    #1;
    chk("byp_stored", rda_n, 32'hA5A5_A5A5);
    do_cycle();

    // Scoreboard set / clear / collision on x3
    ra = 5'd3;
    ie = 1'b1; ia = 5'd3;
    do_cycle();
    idle();
    chk("sb_set", {31'd0, bv_b[3]}, 32'd1);
    do_cycle();
    we = 1'b1; wa = 5'd3; wd = 32'd1;
    do_cycle();
    idle();
    chk("sb_clr", {31'd0, bv_b[3]}, 32'd0);
    do_cycle();
    we = 1'b1; wa = 5'd3; wd = 32'd2; ie = 1'b1; ia = 5'd3;
    do_cycle();
    idle();
    chk("sb_coll", {31'd0, bv_b[3]}, 32'd1);
    chk("sb_coll_x3", rda_n, 32'd2);
    do_cycle();

    // Independence sweep
    for (int n = 1; n < 32; n++) begin
      we = 1'b1; wa = 5'(n); wd = 32'(n) * 32'h0101_0101;
      do_cycle();
    end
    idle();
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        ra = 5'(a); rb = 5'(b);
        do_cycle();
      end
    end

    // Random traffic including forwarding hits, collisions and stray resets
    for (int i = 0; i < 3000; i++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      ie = 1'($urandom_range(0, 1));
      ia = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? ia : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_clear();
      end else begin
        rst = 1'b0;
      end
      do_cycle();
    end
    rst = 1'b0;
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
